// File: rtl/raptor64_set_pipe.sv
// raptor64_set_pipe: two-stage SIMD set/compare (and optional min/max) pipeline.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   valid_i / ready_o     request handshake; ready_o is combinational
//   op_i [3:0]            0 EQ 1 NE 2 LT 3 LE 4 GT 5 GE 6 LTU 7 LEU 8 GTU 9 GEU
//                         10 MIN 11 MAX 12 MINU 13 MAXU (14-15 yield 0)
//   lanes_i [1:0]         0: one WID lane, 1: two, 2: four, 3: eight lanes
//   a_i, b_i [WID-1:0]    operands
//   tag_i / tag_o         sideband tag travelling with each operation
//   valid_o / ready_i     result handshake
//   o [WID-1:0]           result
//
// Build option: define SET_MINMAX_EN to implement op codes 10-13; otherwise
// they return 0 and S1 carries no operand copies.
//
// Multi-lane modes assume each lane is a whole power-of-two number of bytes
// (e.g. WID=64 or 128 for all lane modes).
module raptor64_set_pipe #(
    parameter int unsigned WID  = 64,
    parameter int unsigned TAGW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      op_i,
    input  logic [1:0]      lanes_i,
    input  logic [WID-1:0]  a_i,
    input  logic [WID-1:0]  b_i,
    input  logic [TAGW-1:0] tag_i,
    output logic [TAGW-1:0] tag_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [WID-1:0]  o
);

    localparam int unsigned NB = WID / 8;

    typedef enum logic [3:0] {
        OP_EQ = 4'd0,  OP_NE  = 4'd1,  OP_LT   = 4'd2,  OP_LE   = 4'd3,
        OP_GT = 4'd4,  OP_GE  = 4'd5,  OP_LTU  = 4'd6,  OP_LEU  = 4'd7,
        OP_GTU = 4'd8, OP_GEU = 4'd9,  OP_MIN  = 4'd10, OP_MAX  = 4'd11,
        OP_MINU = 4'd12, OP_MAXU = 4'd13
    } op_e;

    // S1 state
    logic            v1_q, v1_d;
    logic [3:0]      op1_q, op1_d;
    logic [1:0]      lanes1_q, lanes1_d;
    logic [TAGW-1:0] tag1_q, tag1_d;
    logic [NB-1:0]   eq1_q, eq1_d, ltu1_q, ltu1_d, lts1_q, lts1_d;
`ifdef SET_MINMAX_EN
    logic [WID-1:0]  a1_q, a1_d, b1_q, b1_d;
`endif
    // S2 state
    logic            v2_q, v2_d;
    logic [TAGW-1:0] tag2_q, tag2_d;
    logic [WID-1:0]  o_q, o_d;

    logic            s2_adv, accept;
    logic [WID-1:0]  res;
    logic [NB-1:0]   lane_lt, lane_eq;

    assign s2_adv  = !v2_q || ready_i;
    assign ready_o = !v1_q || s2_adv;
    assign accept  = valid_i && ready_o;
    assign valid_o = v2_q;
    assign tag_o   = tag2_q;
    assign o       = o_q;

    // S1: per-byte partials plus the control fields of the accepted request.
    always_comb begin
        v1_d     = ready_o ? valid_i : v1_q;
        op1_d    = op1_q;
        lanes1_d = lanes1_q;
        tag1_d   = tag1_q;
        eq1_d    = eq1_q;
        ltu1_d   = ltu1_q;
        lts1_d   = lts1_q;
`ifdef SET_MINMAX_EN
        a1_d     = a1_q;
        b1_d     = b1_q;
`endif
        if (accept) begin
            op1_d    = op_i;
            lanes1_d = lanes_i;
            tag1_d   = tag_i;
            for (int unsigned i = 0; i < NB; i++) begin
                eq1_d[i]  = a_i[8*i +: 8] == b_i[8*i +: 8];
                ltu1_d[i] = a_i[8*i +: 8] <  b_i[8*i +: 8];
                lts1_d[i] = $signed(a_i[8*i +: 8]) < $signed(b_i[8*i +: 8]);
            end
`ifdef SET_MINMAX_EN
            a1_d = a_i;
            b1_d = b_i;
`endif
        end
    end

    // S2: fold the byte partials into per-lane less-than/equal, then form o.
    always_comb begin
        int unsigned lbm;
        int unsigned top_idx;
        logic        sgn, first, top, lt_run, eq_run, lt, eq, cmp, sel_a;
        logic        is_cmp;
        op_e         op;

        op      = op_e'(op1_q);
        lbm     = (NB >> lanes1_q) - 1;
        sgn     = op inside {OP_LT, OP_LE, OP_GT, OP_GE, OP_MIN, OP_MAX};
        is_cmp  = op1_q <= 4'd9;
        lt_run  = 1'b0;
        eq_run  = 1'b1;
        lane_lt = '0;
        lane_eq = '0;
        res     = '0;
        cmp     = 1'b0;
        sel_a   = 1'b0;
        top_idx = 0;
        first   = 1'b0;
        top     = 1'b0;
        lt      = 1'b0;
        eq      = 1'b0;

        // Bytes are scanned LSB upward; a higher byte overrides the lower
        // result unless it is equal. Only the top byte of a lane is signed.
        for (int unsigned i = 0; i < NB; i++) begin
            if (lanes1_q == 2'd0) begin
                first = (i == 0);
                top   = (i == NB - 1);
            end else begin
                first = (i & lbm) == 0;
                top   = (i & lbm) == lbm;
            end
            lt_run = ((top && sgn) ? lts1_q[i] : ltu1_q[i]) |
                     (eq1_q[i] & (first ? 1'b0 : lt_run));
            eq_run = eq1_q[i] & (first ? 1'b1 : eq_run);
            lane_lt[i] = lt_run;
            lane_eq[i] = eq_run;
        end

        for (int unsigned i = 0; i < NB; i++) begin
            top_idx = (lanes1_q == 2'd0) ? NB - 1 : (i | lbm);
            lt = lane_lt[top_idx];
            eq = lane_eq[top_idx];
            case (op)
                OP_EQ:           cmp = eq;
                OP_NE:           cmp = !eq;
                OP_LT, OP_LTU:   cmp = lt;
                OP_LE, OP_LEU:   cmp = lt | eq;
                OP_GT, OP_GTU:   cmp = !(lt | eq);
                OP_GE, OP_GEU:   cmp = !lt;
                default:         cmp = 1'b0;
            endcase
            sel_a = (op == OP_MIN || op == OP_MINU) ? (lt | eq) : !lt;
            if (is_cmp) begin
                if (lanes1_q == 2'd0) res[0] = cmp;
                else                  res[8*i +: 8] = {8{cmp}};
            end
`ifdef SET_MINMAX_EN
            else if (op1_q <= 4'd13) begin
                res[8*i +: 8] = sel_a ? a1_q[8*i +: 8] : b1_q[8*i +: 8];
            end
`endif
        end
    end

    always_comb begin
        v2_d   = s2_adv ? v1_q : v2_q;
        tag2_d = tag2_q;
        o_d    = o_q;
        if (s2_adv && v1_q) begin
            tag2_d = tag1_q;
            o_d    = res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            op1_q    <= '0;
            lanes1_q <= '0;
            tag1_q   <= '0;
            eq1_q    <= '0;
            ltu1_q   <= '0;
            lts1_q   <= '0;
`ifdef SET_MINMAX_EN
            a1_q     <= '0;
            b1_q     <= '0;
`endif
            v2_q     <= 1'b0;
            tag2_q   <= '0;
            o_q      <= '0;
        end else begin
            v1_q     <= v1_d;
            op1_q    <= op1_d;
            lanes1_q <= lanes1_d;
            tag1_q   <= tag1_d;
            eq1_q    <= eq1_d;
            ltu1_q   <= ltu1_d;
            lts1_q   <= lts1_d;
`ifdef SET_MINMAX_EN
            a1_q     <= a1_d;
            b1_q     <= b1_d;
`endif
            v2_q     <= v2_d;
            tag2_q   <= tag2_d;
            o_q      <= o_d;
        end
    end

endmodule

// File: tb/tb_raptor64_set_pipe.sv
module tb_raptor64_set_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, valid_o, ready_i;
    logic [3:0]  op_i;
    logic [1:0]  lanes_i;
    logic [63:0] a_i, b_i, o;
    logic [5:0]  tag_i, tag_o;

    typedef struct {
        logic [5:0]  tag;
        logic [63:0] o;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic        stalled = 1'b0;
    logic [63:0] hold_o;
    logic [5:0]  hold_tag;

    always #5 clk = ~clk;

    raptor64_set_pipe #(.WID(64), .TAGW(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .lanes_i(lanes_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
        .tag_o(tag_o), .valid_o(valid_o), .ready_i(ready_i), .o(o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on each accepted result; held-output check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (valid_o) begin
            if (stalled) begin
                total++;
                if (o !== hold_o || tag_o !== hold_tag) begin
                    bad++;
                    $display("FAIL stall_hold: got o=%h tag=%0d expected o=%h tag=%0d",
                             o, tag_o, hold_o, hold_tag);
                end
            end
            if (ready_i) begin
                stalled = 1'b0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got o=%h tag=%0d expected none", o, tag_o);
                end else begin
                    e = sb.pop_front();
                    if (o !== e.o || tag_o !== e.tag) begin
                        bad++;
                        $display("FAIL result: got o=%h tag=%0d expected o=%h tag=%0d",
                                 o, tag_o, e.o, e.tag);
                    end
                end
            end else begin
                stalled  = 1'b1;
                hold_o   = o;
                hold_tag = tag_o;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [1:0] ln, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] tg, input logic [63:0] exp_o);
        int n = 0;
        op_i = op; lanes_i = ln; a_i = a; b_i = b; tag_i = tg; valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back('{tg, exp_o});
                break;
            end
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout: got ready_o=0 expected 1 (tag %0d)", tg);
                break;
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    logic [63:0] mm_min, mm_maxu;

    initial begin
`ifdef SET_MINMAX_EN
        mm_min  = 64'h80000000_00000005;
        mm_maxu = 64'h80000000_00000009;
`else
        mm_min  = 64'd0;
        mm_maxu = 64'd0;
`endif
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = '0; lanes_i = '0; a_i = '0; b_i = '0; tag_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_o", o, 64'd0);
        check("rst_tag_o", 64'(tag_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accepted at edge k, valid_o visible after edge k+1.
        op_i = 4'd2; lanes_i = 2'd0; a_i = '1; b_i = '0; tag_i = 6'd1; valid_i = 1'b1;
        sb.push_back('{6'd1, 64'd1});
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("lat_stage1", 64'(valid_o), 64'd0);
        @(posedge clk); #1;
        check("lat_stage2", 64'(valid_o), 64'd1);

        send(4'd6,  2'd0, '1, '0, 6'd2, 64'd0);
        send(4'd0,  2'd3, 64'h0011223344556677, 64'h0011FF3344006677, 6'd3, 64'hFFFF00FFFF00FFFF);
        send(4'd10, 2'd1, 64'h80000000_00000005, 64'h00000001_00000009, 6'd4, mm_min);
        send(4'd13, 2'd1, 64'h80000000_00000005, 64'h00000001_00000009, 6'd5, mm_maxu);
        send(4'd5,  2'd2, 64'h8000_0001_7FFF_0005, 64'h0000_0001_8000_0005, 6'd6, 64'h0000_FFFF_FFFF_FFFF);
        send(4'd9,  2'd2, 64'h8000_0001_7FFF_0005, 64'h0000_0001_8000_0005, 6'd7, 64'hFFFF_FFFF_0000_FFFF);
        send(4'd1,  2'd0, 64'd5, 64'd5, 6'd8, 64'd0);
        send(4'd4,  2'd0, 64'h00000001_00000000, 64'h00000000_FFFFFFFF, 6'd9, 64'd1);
        send(4'd3,  2'd0, 64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 6'd10, 64'd1);
        send(4'd8,  2'd0, 64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 6'd11, 64'd1);
        send(4'd7,  2'd3, 64'h0102030405060708, 64'h01010404FF000709, 6'd12, 64'hFF00FFFFFF00FFFF);
        send(4'd2,  2'd3, 64'h807F00FF00000000, 64'h7F80FF0000000000, 6'd13, 64'hFF0000FF00000000);
        send(4'd14, 2'd3, 64'd1, 64'd2, 6'd14, 64'd0);
        send(4'd15, 2'd0, 64'd1, 64'd2, 6'd15, 64'd0);
        drain();

        // Back-to-back burst with a three-cycle consumer stall.
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(4'd0, 2'd0, 64'(t), 64'd3, 6'(t), (t == 3) ? 64'd1 : 64'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Reset with a full, stalled pipe.
        ready_i = 1'b0;
        send(4'd0, 2'd3, 64'd0, 64'd0, 6'd20, '1);
        send(4'd0, 2'd3, 64'd0, 64'd0, 6'd21, '1);
        check("full_ready_o", 64'(ready_o), 64'd0);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        check("mid_rst_valid_o", 64'(valid_o), 64'd0);
        check("mid_rst_o", o, 64'd0);
        check("mid_rst_tag_o", 64'(tag_o), 64'd0);
        check("mid_rst_ready_o", 64'(ready_o), 64'd1);
        rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(valid_o), 64'd0);

        send(4'd11, 2'd0, 64'd7, 64'd9, 6'd30,
`ifdef SET_MINMAX_EN
             64'd9
`else
             64'd0
`endif
        );
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
